simple_proc_ctrl: RTL and testbench



---
 rtl/simple_proc_pkg.sv | 60 ++++++
 rtl/simple_proc_ctrl_if.sv | 34 +++
 rtl/simple_proc_ctrl_cond_check.sv | 35 +++
 rtl/simple_proc_ctrl.sv | 122 ++++++++++++
 tb/tb_simple_proc_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/simple_proc_pkg.sv
// Shared definitions for the simple processor control path.
// Covers opcodes, condition codes, sequencer states and instruction field positions.
package simple_proc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_ORR = 4'h3,
    OP_AND  = 4'h4, OP_EOR = 4'h5, OP_MOVN = 4'h6, OP_MOV = 4'h7,
    OP_LSR  = 4'h8, OP_LSL = 4'h9, OP_ROR = 4'hA, OP_CMP = 4'hB,
    OP_ADR  = 4'hC, OP_LDR = 4'hD, OP_STR = 4'hE, OP_NOP = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_MEM       = 3'd5
  } state_e;

  localparam int COND_LSB = 16;
  localparam int OP_LSB   = 12;
  localparam int RD_LSB   = 9;
  localparam int RN_LSB   = 6;
  localparam int RM_LSB   = 3;
  localparam int IMM_LSB  = 0;

  // imm7 deliberately overlaps the rn/rm fields
  function automatic logic [3:0] f_cond(input logic [19:0] ir);
    return ir[COND_LSB +: 4];
  endfunction

  function automatic logic [3:0] f_opcode(input logic [19:0] ir);
    return ir[OP_LSB +: 4];
  endfunction

  function automatic logic [2:0] f_rd(input logic [19:0] ir);
    return ir[RD_LSB +: 3];
  endfunction

  function automatic logic [2:0] f_rn(input logic [19:0] ir);
    return ir[RN_LSB +: 3];
  endfunction

  function automatic logic [2:0] f_rm(input logic [19:0] ir);
    return ir[RM_LSB +: 3];
  endfunction

  function automatic logic [6:0] f_imm7(input logic [19:0] ir);
    return ir[IMM_LSB +: 7];
  endfunction

endpackage

// File: rtl/simple_proc_ctrl_if.sv
// Fetch, ALU, register-file and data-memory signals between the sequencer and the datapath.
interface simple_proc_ctrl_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 20
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [3:0]         flags_nzcv;
  logic [3:0]         alu_opcode;
  logic [6:0]         alu_imm;
  logic               condition_success;
  logic [2:0]         rf_ra_addr;
  logic [2:0]         rf_rb_addr;
  logic               rf_we;
  logic [2:0]         rf_wa_addr;
  logic               rf_wr_sel;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;

  modport master (
    output imem_req, imem_addr, alu_opcode, alu_imm, condition_success,
           rf_ra_addr, rf_rb_addr, rf_we, rf_wa_addr, rf_wr_sel, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, flags_nzcv, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, alu_opcode, alu_imm, condition_success,
           rf_ra_addr, rf_rb_addr, rf_we, rf_wa_addr, rf_wr_sel, dmem_req, dmem_we,
    output imem_ack, imem_rdata, flags_nzcv, dmem_ack
  );
endinterface

// File: rtl/simple_proc_ctrl_cond_check.sv
// Combinational condition-code evaluator against {N,Z,C,V}.
// Kept standalone so a branch unit can reuse it.
module cond_check
  import simple_proc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    pass = 1'b0;
    case (cond)
      CC_EQ: pass = z;
      CC_NE: pass = !z;
      CC_CS: pass = c;
      CC_CC: pass = !c;
      CC_MI: pass = n;
      CC_PL: pass = !n;
      CC_VS: pass = v;
      CC_VC: pass = !v;
      CC_HI: pass = c && !z;
      CC_LS: pass = !c || z;
      CC_GE: pass = (n == v);
      CC_LT: pass = (n != v);
      CC_GT: pass = !z && (n == v);
      CC_LE: pass = z || (n != v);
      CC_AL: pass = 1'b1;
      CC_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/simple_proc_ctrl.sv
// Multi-cycle fetch/decode/control sequencer feeding the ALU, register file and data memory.
//
// state     | meaning
// IDLE      | waiting for run
// FETCH     | imem_req held until imem_ack; IR and PC updated on ack
// DECODE    | read addresses out, condition evaluated and latched
// EXECUTE   | ALU opcode/immediate driven, condition_success high
// WRITEBACK | ALU result written to rd (not for CMP)
// MEM       | dmem handshake for LDR/STR; LDR writes rd on the ack cycle
module simple_proc_ctrl
  import simple_proc_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic busy,
  simple_proc_ctrl_if.master bus
);
  state_e             state, state_nxt, after_instr;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               cond_pass, cond_ok;
  logic [3:0]         ir_cond, ir_op;
  logic [2:0]         ir_rd, ir_rn, ir_rm;
  logic               is_mem_op, read_phase;

  assign ir_cond = f_cond(ir);
  assign ir_op   = f_opcode(ir);
  assign ir_rd   = f_rd(ir);
  assign ir_rn   = f_rn(ir);
  assign ir_rm   = f_rm(ir);

  assign is_mem_op   = (ir_op == OP_LDR) || (ir_op == OP_STR);
  assign after_instr = run ? ST_FETCH : ST_IDLE;
  assign read_phase  = state inside {ST_DECODE, ST_EXECUTE, ST_WRITEBACK, ST_MEM};

  cond_check u_cond_check (
    .cond (ir_cond),
    .nzcv (bus.flags_nzcv),
    .pass (cond_ok)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      ir        <= '0;
      cond_pass <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_FETCH && bus.imem_ack) begin
        ir <= bus.imem_rdata;
        pc <= pc + PC_W'(1);
      end
      if (state == ST_DECODE) cond_pass <= cond_ok;
    end
  end

  // A skipped instruction is a boundary, so run=0 takes effect there as well
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (run) state_nxt = ST_FETCH;
      ST_FETCH:     if (bus.imem_ack) state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (ir_op == OP_NOP || !cond_ok) state_nxt = after_instr;
        else if (is_mem_op)              state_nxt = ST_MEM;
        else                             state_nxt = ST_EXECUTE;
      end
      ST_EXECUTE:   state_nxt = ST_WRITEBACK;
      ST_WRITEBACK: state_nxt = after_instr;
      ST_MEM:       if (bus.dmem_ack) state_nxt = after_instr;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign bus.imem_addr = pc;
  assign busy          = (state != ST_IDLE);

  always_comb begin
    bus.imem_req          = 1'b0;
    bus.alu_opcode        = OP_NOP;
    bus.alu_imm           = '0;
    bus.condition_success = 1'b0;
    bus.rf_ra_addr        = '0;
    bus.rf_rb_addr        = '0;
    bus.rf_we             = 1'b0;
    bus.rf_wa_addr        = '0;
    bus.rf_wr_sel         = 1'b0;
    bus.dmem_req          = 1'b0;
    bus.dmem_we           = 1'b0;
    if (read_phase) begin
      bus.rf_ra_addr = ir_rn;
      bus.rf_rb_addr = (ir_op == OP_STR) ? ir_rd : ir_rm;
    end
    case (state)
      ST_FETCH: bus.imem_req = 1'b1;
      ST_EXECUTE: begin
        bus.alu_opcode        = ir_op;
        bus.alu_imm           = f_imm7(ir);
        bus.condition_success = cond_pass;
      end
      ST_WRITEBACK: begin
        bus.rf_we      = (ir_op != OP_CMP);
        bus.rf_wa_addr = ir_rd;
      end
      ST_MEM: begin
        bus.dmem_req   = 1'b1;
        bus.dmem_we    = (ir_op == OP_STR);
        bus.rf_wa_addr = ir_rd;
        if (bus.dmem_ack && ir_op == OP_LDR) begin
          bus.rf_we     = 1'b1;
          bus.rf_wr_sel = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_simple_proc_ctrl.sv
// Self-checking bench for simple_proc_ctrl: directed scenarios plus random instructions
// checked against an instruction-level timing/effect model.
module tb_simple_proc_ctrl;
  logic clk = 1'b0;
  logic rst, run, busy;
  int   errors = 0;
  int   checks = 0;
  int   model_pc = 0;

  simple_proc_ctrl_if #(.PC_W(8), .INSTR_W(20)) bus ();

  simple_proc_ctrl #(.PC_W(8), .INSTR_W(20)) dut (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .busy (busy),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cycles;
    int   exec;
    int   we;
    bit   sel;
    int   dreq;
    bit   dwe;
    logic [2:0] rb_mem;
  } exp_t;

  // observations from one instruction
  int         o_cycles, o_req_cycles, o_exec_cycles, o_cs_cycles, o_we_cycles, o_dreq_cycles;
  bit         o_addr_moved, o_dwe, o_we_sel, o_we_with_ack, o_end_busy;
  logic [7:0] o_addr_first, o_exp_addr;
  logic [3:0] o_exec_op;
  logic [6:0] o_exec_imm;
  logic [2:0] o_we_addr, o_rb_mem, o_ra_mem, o_ra_exec, o_rb_exec;

  function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [19:0] instr, input logic [3:0] nzcv,
                                 input int fwait, input int dwait);
    exp_t e;
    logic [3:0] op;
    op = instr[15:12];
    e = '{cycles: 0, exec: 0, we: 0, sel: 1'b0, dreq: 0, dwe: 1'b0, rb_mem: 3'd0};
    if (op == 4'hF || !cond_ok(instr[19:16], nzcv)) begin
      e.cycles = fwait + 2;
    end else if (op == 4'hD || op == 4'hE) begin
      e.dreq   = dwait + 1;
      e.cycles = fwait + 2 + e.dreq;
      e.we     = (op == 4'hD) ? 1 : 0;
      e.sel    = 1'b1;
      e.dwe    = (op == 4'hE);
      e.rb_mem = (op == 4'hE) ? instr[11:9] : instr[5:3];
    end else begin
      e.exec   = 1;
      e.cycles = fwait + 4;
      e.we     = (op == 4'hB) ? 0 : 1;
    end
    return e;
  endfunction

  // Called at a negedge with the DUT in FETCH; returns at the negedge of the next boundary.
  task automatic drive_instr(input logic [19:0] instr, input logic [3:0] nzcv, input int fwait,
                             input int dwait, input bit stray, input int drop_run_at);
    int cyc, fw, dw;
    bit fetched;
    fw = fwait; dw = dwait; fetched = 1'b0; cyc = 0;
    o_req_cycles = 0; o_exec_cycles = 0; o_cs_cycles = 0; o_we_cycles = 0; o_dreq_cycles = 0;
    o_addr_moved = 1'b0; o_dwe = 1'b0; o_we_sel = 1'b0; o_we_with_ack = 1'b0;
    o_addr_first = 8'hxx; o_exec_op = 4'hx; o_exec_imm = 7'hxx; o_we_addr = 3'hx;
    o_rb_mem = 3'hx; o_ra_mem = 3'hx; o_ra_exec = 3'hx; o_rb_exec = 3'hx;
    o_exp_addr = model_pc[7:0];
    bus.flags_nzcv = nzcv;
    while (!(fetched && (bus.imem_req || !busy)) && cyc < 64) begin
      bus.imem_ack   = 1'b0;
      bus.dmem_ack   = 1'b0;
      bus.imem_rdata = 20'($urandom);
      if (cyc == drop_run_at) run = 1'b0;
      if (bus.imem_req) begin
        if (o_req_cycles == 0) o_addr_first = bus.imem_addr;
        else if (bus.imem_addr !== o_addr_first) o_addr_moved = 1'b1;
        o_req_cycles++;
        if (fw > 0) fw--;
        else begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = instr;
          fetched        = 1'b1;
        end
      end else if (stray) bus.imem_ack = 1'($urandom_range(0, 1));
      if (bus.dmem_req) begin
        if (dw > 0) dw--;
        else bus.dmem_ack = 1'b1;
      end else if (stray) bus.dmem_ack = 1'($urandom_range(0, 1));
      #1;
      if (bus.alu_opcode !== 4'hF) begin
        o_exec_cycles++;
        o_exec_op  = bus.alu_opcode;
        o_exec_imm = bus.alu_imm;
        o_ra_exec  = bus.rf_ra_addr;
        o_rb_exec  = bus.rf_rb_addr;
      end
      if (bus.condition_success) o_cs_cycles++;
      if (bus.rf_we) begin
        o_we_cycles++;
        o_we_addr     = bus.rf_wa_addr;
        o_we_sel      = bus.rf_wr_sel;
        o_we_with_ack = bus.dmem_ack;
      end
      if (bus.dmem_req) begin
        o_dreq_cycles++;
        o_dwe    = bus.dmem_we;
        o_rb_mem = bus.rf_rb_addr;
        o_ra_mem = bus.rf_ra_addr;
      end
      cyc++;
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    o_cycles   = cyc;
    o_end_busy = busy;
    if (fetched) model_pc = (model_pc + 1) % 256;
  endtask

  task automatic go_fetch();
    int n;
    run = 1'b1;
    n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0;
    bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0; bus.imem_rdata = '0; bus.flags_nzcv = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.alu_opcode !== 4'hF) begin errors++; $display("FAIL reset_alu_opcode: got %h want F", bus.alu_opcode); end
    checks++; if (bus.imem_addr !== 8'd0) begin errors++; $display("FAIL reset_imem_addr: got %0d want 0", bus.imem_addr); end
    checks++; if ({bus.imem_req, bus.dmem_req, bus.rf_we, bus.condition_success, bus.dmem_we} !== 5'b0)
      begin errors++; $display("FAIL reset_strobes: got %b want 00000",
        {bus.imem_req, bus.dmem_req, bus.rf_we, bus.condition_success, bus.dmem_we}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_without_run: busy got %b want 0", busy); end
    run = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL run_starts_fetch: imem_req got %b want 1", bus.imem_req); end
    model_pc = 0;
  endtask

  task automatic test_add();
    drive_instr(20'hE0458, 4'($urandom), 0, 0, 1'b0, -1);
    checks++; if (o_cycles != 4) begin errors++; $display("FAIL add_cycles: got %0d want 4", o_cycles); end
    checks++; if (o_addr_first !== 8'd0) begin errors++; $display("FAIL add_fetch_addr: got %0d want 0", o_addr_first); end
    checks++; if (o_exec_op !== 4'h0) begin errors++; $display("FAIL add_alu_opcode: got %h want 0", o_exec_op); end
    checks++; if (o_cs_cycles != 1) begin errors++; $display("FAIL add_cond_success: got %0d cycles want 1", o_cs_cycles); end
    checks++; if ({o_ra_exec, o_rb_exec} !== {3'd1, 3'd3}) begin errors++; $display("FAIL add_read_addr: got ra=%0d rb=%0d want 1 3", o_ra_exec, o_rb_exec); end
    checks++; if (o_we_cycles != 1 || o_we_addr !== 3'd2 || o_we_sel !== 1'b0)
      begin errors++; $display("FAIL add_writeback: got we=%0d wa=%0d sel=%b want 1 2 0", o_we_cycles, o_we_addr, o_we_sel); end
    checks++; if (bus.imem_addr !== 8'd1) begin errors++; $display("FAIL add_next_addr: got %0d want 1", bus.imem_addr); end
  endtask

  task automatic test_cond_skip();
    drive_instr(20'h10458, 4'b0100, 0, 0, 1'b0, -1);
    checks++; if (o_cycles != 2) begin errors++; $display("FAIL ne_skip_cycles: got %0d want 2", o_cycles); end
    checks++; if (o_exec_cycles != 0 || o_cs_cycles != 0 || o_we_cycles != 0)
      begin errors++; $display("FAIL ne_skip_effects: got exec=%0d cs=%0d we=%0d want 0 0 0", o_exec_cycles, o_cs_cycles, o_we_cycles); end
    drive_instr(20'h10458, 4'b0000, 0, 0, 1'b0, -1);
    checks++; if (o_cycles != 4 || o_exec_cycles != 1 || o_we_cycles != 1)
      begin errors++; $display("FAIL ne_exec: got cycles=%0d exec=%0d we=%0d want 4 1 1", o_cycles, o_exec_cycles, o_we_cycles); end
  endtask

  task automatic test_cmp_cond();
    drive_instr(20'hEB050, 4'b0000, 0, 0, 1'b0, -1);
    checks++; if (o_exec_op !== 4'hB || o_we_cycles != 0)
      begin errors++; $display("FAIL cmp_no_write: got op=%h we=%0d want B 0", o_exec_op, o_we_cycles); end
    drive_instr(20'h07A08, 4'b0100, 0, 0, 1'b0, -1);
    checks++; if (o_exec_op !== 4'h7 || o_we_cycles != 1 || o_we_addr !== 3'd5)
      begin errors++; $display("FAIL eq_mov_exec: got op=%h we=%0d wa=%0d want 7 1 5", o_exec_op, o_we_cycles, o_we_addr); end
  endtask

  task automatic test_mem();
    drive_instr(20'hED880, 4'($urandom), 0, 3, 1'b0, -1);
    checks++; if (o_dreq_cycles != 4 || o_dwe !== 1'b0)
      begin errors++; $display("FAIL ldr_req: got req_cycles=%0d we=%b want 4 0", o_dreq_cycles, o_dwe); end
    checks++; if (o_we_cycles != 1 || o_we_sel !== 1'b1 || o_we_with_ack !== 1'b1 || o_we_addr !== 3'd4)
      begin errors++; $display("FAIL ldr_write: got we=%0d sel=%b on_ack=%b wa=%0d want 1 1 1 4", o_we_cycles, o_we_sel, o_we_with_ack, o_we_addr); end
    checks++; if (o_cycles != 6) begin errors++; $display("FAIL ldr_cycles: got %0d want 6", o_cycles); end
    drive_instr(20'hEECC8, 4'($urandom), 0, 0, 1'b0, -1);
    checks++; if (o_dwe !== 1'b1 || o_rb_mem !== 3'd6 || o_ra_mem !== 3'd3 || o_we_cycles != 0)
      begin errors++; $display("FAIL str_ctrl: got we=%b rb=%0d ra=%0d rf_we=%0d want 1 6 3 0", o_dwe, o_rb_mem, o_ra_mem, o_we_cycles); end
    checks++; if (o_cycles != 3) begin errors++; $display("FAIL str_cycles: got %0d want 3", o_cycles); end
  endtask

  task automatic test_pc_wrap_stall();
    int n;
    n = 0;
    while (model_pc != 255 && n < 300) begin
      drive_instr(20'hEF000, 4'($urandom), 0, 0, 1'b0, -1);
      n++;
    end
    drive_instr(20'hEF000, 4'($urandom), 0, 0, 1'b0, -1);
    checks++; if (o_addr_first !== 8'd255) begin errors++; $display("FAIL wrap_addr_255: got %0d want 255", o_addr_first); end
    drive_instr(20'hEF000, 4'($urandom), 5, 0, 1'b0, -1);
    checks++; if (o_addr_first !== 8'd0) begin errors++; $display("FAIL wrap_addr_0: got %0d want 0", o_addr_first); end
    // five ack-less cycles then the ack cycle itself
    checks++; if (o_req_cycles != 6 || o_addr_moved !== 1'b0 || o_cycles != 7)
      begin errors++; $display("FAIL fetch_stall: got req=%0d moved=%b cycles=%0d want 6 0 7", o_req_cycles, o_addr_moved, o_cycles); end
  endtask

  task automatic test_random();
    logic [19:0] instr;
    logic [3:0]  nzcv;
    int          fw, dw;
    exp_t        e;
    for (int i = 0; i < 80; i++) begin
      instr = 20'($urandom);
      nzcv  = 4'($urandom);
      fw    = $urandom_range(0, 2);
      dw    = $urandom_range(0, 3);
      e     = model(instr, nzcv, fw, dw);
      drive_instr(instr, nzcv, fw, dw, 1'b1, -1);
      checks++; if (o_cycles != e.cycles || o_addr_first !== o_exp_addr)
        begin errors++; $display("FAIL rnd%0d_timing: instr=%h got cycles=%0d addr=%0d want %0d %0d", i, instr, o_cycles, o_addr_first, e.cycles, o_exp_addr); end
      checks++; if (o_exec_cycles != e.exec || o_cs_cycles != e.exec || o_we_cycles != e.we || o_dreq_cycles != e.dreq)
        begin errors++; $display("FAIL rnd%0d_effects: instr=%h nzcv=%b got exec=%0d cs=%0d we=%0d dreq=%0d want %0d %0d %0d %0d",
          i, instr, nzcv, o_exec_cycles, o_cs_cycles, o_we_cycles, o_dreq_cycles, e.exec, e.exec, e.we, e.dreq); end
      if (e.exec != 0) begin
        checks++; if ({o_exec_op, o_exec_imm, o_ra_exec, o_rb_exec} !== {instr[15:12], instr[6:0], instr[8:6], instr[5:3]})
          begin errors++; $display("FAIL rnd%0d_alu: instr=%h got op=%h imm=%h ra=%0d rb=%0d", i, instr, o_exec_op, o_exec_imm, o_ra_exec, o_rb_exec); end
      end
      if (e.we != 0) begin
        checks++; if (o_we_addr !== instr[11:9] || o_we_sel !== e.sel)
          begin errors++; $display("FAIL rnd%0d_wb: instr=%h got wa=%0d sel=%b want %0d %b", i, instr, o_we_addr, o_we_sel, instr[11:9], e.sel); end
      end
      if (e.dreq != 0) begin
        checks++; if (o_dwe !== e.dwe || o_rb_mem !== e.rb_mem || o_ra_mem !== instr[8:6])
          begin errors++; $display("FAIL rnd%0d_mem: instr=%h got we=%b rb=%0d ra=%0d want %b %0d %0d", i, instr, o_dwe, o_rb_mem, o_ra_mem, e.dwe, e.rb_mem, instr[8:6]); end
      end
    end
  endtask

  task automatic test_reset_run();
    bus.flags_nzcv = 4'b0000;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 20'hED880;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_req: got %b want 1", bus.dmem_req); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.dmem_req !== 1'b0 || bus.imem_req !== 1'b0 || bus.rf_we !== 1'b0)
      begin errors++; $display("FAIL rst_mid_mem: got busy=%b dreq=%b ireq=%b we=%b want 0 0 0 0", busy, bus.dmem_req, bus.imem_req, bus.rf_we); end
    checks++; if (bus.imem_addr !== 8'd0 || bus.alu_opcode !== 4'hF)
      begin errors++; $display("FAIL rst_mid_mem_pc: got addr=%0d op=%h want 0 F", bus.imem_addr, bus.alu_opcode); end
    rst = 1'b0;
    model_pc = 0;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd0)
      begin errors++; $display("FAIL restart_fetch: got req=%b addr=%0d want 1 0", bus.imem_req, bus.imem_addr); end
    drive_instr(20'hE0458, 4'b0000, 0, 0, 1'b0, 2);
    checks++; if (o_cycles != 4 || o_we_cycles != 1 || o_end_busy !== 1'b0)
      begin errors++; $display("FAIL run_drop: got cycles=%0d we=%0d busy=%b want 4 1 0", o_cycles, o_we_cycles, o_end_busy); end
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.imem_req !== 1'b0)
      begin errors++; $display("FAIL stays_idle: got busy=%b req=%b want 0 0", busy, bus.imem_req); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cond_skip();
    test_cmp_cond();
    test_mem();
    test_random();
    test_pc_wrap_stall();
    test_reset_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
